// File: rtl/sha_pkg.sv
// Shared definitions for the SHA control slice: one-hot state encoding and
// the per-algorithm round counts.
package sha_pkg;

   localparam int unsigned SHA1_ROUNDS   = 80;
   localparam int unsigned SHA256_ROUNDS = 64;
   localparam int unsigned SHA512_ROUNDS = 80;

   localparam logic [4:0] ST_IDLE     = 5'b00001;
   localparam logic [4:0] ST_WAIT_BLK = 5'b00010;
   localparam logic [4:0] ST_ROUND    = 5'b00100;
   localparam logic [4:0] ST_UPDATE   = 5'b01000;
   localparam logic [4:0] ST_DONE     = 5'b10000;

   typedef enum logic [4:0] {
      StIdle    = ST_IDLE,
      StWaitBlk = ST_WAIT_BLK,
      StRound   = ST_ROUND,
      StUpdate  = ST_UPDATE,
      StDone    = ST_DONE
   } state_e;

endpackage

// File: rtl/sha_round_ctrl_if.sv
// Host/datapath-facing bundle of the SHA round controller; master is the
// host side, slave is the controller.
interface sha_round_ctrl_if
   import sha_pkg::*;
#(
   parameter int unsigned ROUNDS = SHA256_ROUNDS,
   parameter int unsigned BCW    = 8
);
   localparam int unsigned RW = $clog2(ROUNDS);

   logic           start;
   logic           abort;
   logic           block_valid;
   logic           block_last;
   logic           block_ready;
   logic           digest_ready;
   logic           init;
   logic           load;
   logic           enable;
   logic [RW-1:0]  round;
   logic           round_last;
   logic           update;
   logic           digest_valid;
   logic           busy;
   logic [BCW-1:0] block_cnt;

   modport master (
      output start, abort, block_valid, block_last, digest_ready,
      input  block_ready, init, load, enable, round, round_last, update,
             digest_valid, busy, block_cnt
   );

   modport slave (
      input  start, abort, block_valid, block_last, digest_ready,
      output block_ready, init, load, enable, round, round_last, update,
             digest_valid, busy, block_cnt
   );

endinterface

// File: rtl/sha_round_cnt.sv
// Round index counter: counts 0..ROUNDS-1 while enabled and wraps to 0 after
// the last round so the index reads 0 outside the round phase.
module sha_round_cnt
   import sha_pkg::*;
#(
   parameter int unsigned ROUNDS = SHA256_ROUNDS,
   localparam int unsigned RW = $clog2(ROUNDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [RW-1:0] round,
   output logic          round_last
);

   logic [RW-1:0] round_q;

   assign round      = round_q;
   assign round_last = en & (round_q == RW'(ROUNDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_q <= '0;
      end else if (clr) begin
         round_q <= '0;
      end else if (en) begin
         round_q <= round_last ? '0 : round_q + RW'(1);
      end
   end

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA compression controller: sequences IV init, block loads, the round loop
// and hash update per block, then presents the digest via valid/ready.
module sha_round_ctrl
   import sha_pkg::*;
#(
   parameter int unsigned ROUNDS = SHA256_ROUNDS,
   parameter int unsigned BCW    = 8
) (
   input logic              clk,
   input logic              rst_n,
   sha_round_ctrl_if.slave  bus
);

   localparam int unsigned  RW      = $clog2(ROUNDS);
   localparam logic [BCW-1:0] cnt_max = '1;

   state_e         state_q;
   logic           last_q;
   logic [BCW-1:0] block_cnt_q;
   logic           abort_act;
   logic           init_w;
   logic           ready_w;
   logic           load_w;
   logic           enable_w;
   logic           update_w;
   logic [RW-1:0]  round_w;
   logic           round_last_w;

   // Abort only matters once a message is in flight; it also masks every strobe.
   assign abort_act = bus.abort & (state_q != StIdle);
   assign init_w    = (state_q == StIdle) & bus.start & ~bus.abort;
   assign ready_w   = (state_q == StWaitBlk) & ~bus.abort;
   assign load_w    = ready_w & bus.block_valid;
   assign enable_w  = (state_q == StRound) & ~bus.abort;
   assign update_w  = (state_q == StUpdate) & ~bus.abort;

   assign bus.init         = init_w;
   assign bus.block_ready  = ready_w;
   assign bus.load         = load_w;
   assign bus.enable       = enable_w;
   assign bus.update       = update_w;
   assign bus.round        = round_w;
   assign bus.round_last   = round_last_w;
   assign bus.digest_valid = (state_q == StDone);
   assign bus.busy         = (state_q != StIdle);
   assign bus.block_cnt    = block_cnt_q;

   sha_round_cnt #(
      .ROUNDS (ROUNDS)
   ) u_round_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (abort_act),
      .en         (enable_w),
      .round      (round_w),
      .round_last (round_last_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         last_q      <= 1'b0;
         block_cnt_q <= '0;
      end else if (abort_act) begin
         state_q     <= StIdle;
         last_q      <= 1'b0;
         block_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (init_w) begin
                  block_cnt_q <= '0;
                  last_q      <= 1'b0;
                  state_q     <= StWaitBlk;
               end
            end
            StWaitBlk: begin
               if (load_w) begin
                  last_q  <= bus.block_last;
                  state_q <= StRound;
                  if (block_cnt_q != cnt_max) begin
                     block_cnt_q <= block_cnt_q + BCW'(1);
                  end
               end
            end
            StRound: begin
               if (round_last_w) begin
                  state_q <= StUpdate;
               end
            end
            StUpdate: begin
               state_q <= last_q ? StDone : StWaitBlk;
            end
            StDone: begin
               if (bus.digest_ready) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Directed bench for sha_round_ctrl: a 64-round/8-bit-counter instance and an
// 80-round/2-bit-counter instance driven from one clock.
module tb_sha_round_ctrl;
   import sha_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   sha_round_ctrl_if #(.ROUNDS(64), .BCW(8)) a ();
   sha_round_ctrl_if #(.ROUNDS(80), .BCW(2)) b ();

   sha_round_ctrl #(.ROUNDS(64), .BCW(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
   sha_round_ctrl #(.ROUNDS(80), .BCW(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in;
      a.start = 0; a.abort = 0; a.block_valid = 0; a.block_last = 0; a.digest_ready = 0;
      b.start = 0; b.abort = 0; b.block_valid = 0; b.block_last = 0; b.digest_ready = 0;
   endtask

   // Leaves instance a in DONE after a single-block message.
   task automatic drive_single_a;
      a.start = 1; #1; tick; a.start = 0;
      a.block_valid = 1; a.block_last = 1; #1; tick;
      a.block_valid = 0; a.block_last = 0;
      repeat (65) tick;
   endtask

   task automatic test_reset;
      clear_in();
      #2 rst_n = 0;
      #1;
      if ({a.init, a.load, a.enable, a.round_last, a.update, a.digest_valid, a.busy,
           a.block_ready} !== 8'h00) begin
         $display("FAIL reset_strobes: got %b want 00000000", {a.init, a.load, a.enable,
                  a.round_last, a.update, a.digest_valid, a.busy, a.block_ready});
         n_bad++;
      end
      n_cmp++;
      if (a.round !== 6'd0 || a.block_cnt !== 8'd0 || b.busy !== 1'b0) begin
         $display("FAIL reset_regs: round=%0d cnt=%0d b_busy=%b want 0 0 0",
                  a.round, a.block_cnt, b.busy);
         n_bad++;
      end
      n_cmp++;
      @(negedge clk) rst_n = 1;
      tick;
   endtask

   task automatic test_single;
      a.start = 1; #1;
      if (a.init !== 1'b1 || a.busy !== 1'b0 || a.load !== 1'b0) begin
         $display("FAIL single_init: init=%b busy=%b load=%b want 1 0 0", a.init, a.busy, a.load);
         n_bad++;
      end
      n_cmp++;
      tick; a.start = 0;
      a.block_valid = 1; a.block_last = 1; #1;
      if (a.block_ready !== 1'b1 || a.load !== 1'b1 || a.init !== 1'b0 || a.enable !== 1'b0) begin
         $display("FAIL single_load: ready=%b load=%b init=%b en=%b want 1 1 0 0",
                  a.block_ready, a.load, a.init, a.enable);
         n_bad++;
      end
      n_cmp++;
      tick; a.block_valid = 0; a.block_last = 0;
      if (a.block_cnt !== 8'd1) begin
         $display("FAIL single_cnt: got %0d want 1", a.block_cnt);
         n_bad++;
      end
      n_cmp++;
      for (int i = 0; i < 64; i++) begin
         if (a.enable !== 1'b1 || a.round !== 6'(i) || a.round_last !== (i == 63) ||
             a.update !== 1'b0) begin
            $display("FAIL single_round: i=%0d en=%b round=%0d last=%b upd=%b want 1 %0d %b 0",
                     i, a.enable, a.round, a.round_last, a.update, i, (i == 63));
            n_bad++;
         end
         n_cmp++;
         tick;
      end
      if (a.update !== 1'b1 || a.enable !== 1'b0 || a.round !== 6'd0 || a.digest_valid !== 1'b0) begin
         $display("FAIL single_update: upd=%b en=%b round=%0d dv=%b want 1 0 0 0",
                  a.update, a.enable, a.round, a.digest_valid);
         n_bad++;
      end
      n_cmp++;
      tick;
      if (a.digest_valid !== 1'b1 || a.busy !== 1'b1 || a.update !== 1'b0) begin
         $display("FAIL single_dv: dv=%b busy=%b upd=%b want 1 1 0", a.digest_valid, a.busy, a.update);
         n_bad++;
      end
      n_cmp++;
      a.digest_ready = 1; #1; tick; a.digest_ready = 0;
      if (a.busy !== 1'b0 || a.digest_valid !== 1'b0 || a.block_ready !== 1'b0) begin
         $display("FAIL single_idle: busy=%b dv=%b ready=%b want 0 0 0",
                  a.busy, a.digest_valid, a.block_ready);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_three_blocks;
      int upd = 0;
      a.start = 1; #1; tick; a.start = 0;
      for (int blk = 1; blk <= 3; blk++) begin
         repeat (5) begin
            if (a.block_ready !== 1'b1 || a.load !== 1'b0) begin
               $display("FAIL three_wait: blk=%0d ready=%b load=%b want 1 0",
                        blk, a.block_ready, a.load);
               n_bad++;
            end
            n_cmp++;
            tick;
         end
         a.block_valid = 1; a.block_last = (blk == 3); #1;
         if (a.load !== 1'b1) begin
            $display("FAIL three_load: blk=%0d got %b want 1", blk, a.load);
            n_bad++;
         end
         n_cmp++;
         tick; a.block_valid = 0; a.block_last = 0;
         if (a.block_cnt !== 8'(blk)) begin
            $display("FAIL three_cnt: got %0d want %0d", a.block_cnt, blk);
            n_bad++;
         end
         n_cmp++;
         repeat (64) begin
            if (a.update) upd++;
            tick;
         end
         if (a.update) upd++;
         if (a.digest_valid !== 1'b0) begin
            $display("FAIL three_dv_early: blk=%0d got %b want 0", blk, a.digest_valid);
            n_bad++;
         end
         n_cmp++;
         tick;
      end
      if (upd !== 3 || a.digest_valid !== 1'b1) begin
         $display("FAIL three_done: updates=%0d dv=%b want 3 1", upd, a.digest_valid);
         n_bad++;
      end
      n_cmp++;
      a.digest_ready = 1; #1; tick; a.digest_ready = 0;
   endtask

   task automatic test_backpressure;
      drive_single_a();
      for (int k = 0; k < 10; k++) begin
         a.start = k[0]; #1;
         if (a.digest_valid !== 1'b1 || a.busy !== 1'b1 || a.init !== 1'b0) begin
            $display("FAIL bp_hold: k=%0d dv=%b busy=%b init=%b want 1 1 0",
                     k, a.digest_valid, a.busy, a.init);
            n_bad++;
         end
         n_cmp++;
         tick;
      end
      a.start = 0;
      if (a.block_cnt !== 8'd1 || a.digest_valid !== 1'b1) begin
         $display("FAIL bp_cnt: cnt=%0d dv=%b want 1 1", a.block_cnt, a.digest_valid);
         n_bad++;
      end
      n_cmp++;
      a.digest_ready = 1; #1; tick; a.digest_ready = 0;
      if (a.busy !== 1'b0) begin
         $display("FAIL bp_release: busy=%b want 0", a.busy);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_abort;
      bit seen = 0;
      a.start = 1; #1; tick; a.start = 0;
      a.block_valid = 1; a.block_last = 1; #1; tick; a.block_valid = 0; a.block_last = 0;
      repeat (30) tick;
      a.abort = 1; #1;
      if (a.round !== 6'd30 || a.update !== 1'b0 || a.enable !== 1'b0 || a.load !== 1'b0) begin
         $display("FAIL abort_cycle: round=%0d upd=%b en=%b load=%b want 30 0 0 0",
                  a.round, a.update, a.enable, a.load);
         n_bad++;
      end
      n_cmp++;
      tick; a.abort = 0;
      if (a.busy !== 1'b0 || a.round !== 6'd0 || a.block_cnt !== 8'd0) begin
         $display("FAIL abort_idle: busy=%b round=%0d cnt=%0d want 0 0 0",
                  a.busy, a.round, a.block_cnt);
         n_bad++;
      end
      n_cmp++;
      repeat (80) begin
         if (a.update || a.digest_valid || a.enable || a.busy) seen = 1;
         tick;
      end
      if (seen !== 1'b0) begin
         $display("FAIL abort_quiet: activity=%b want 0", seen);
         n_bad++;
      end
      n_cmp++;
      // abort in IDLE swallows a simultaneous start
      a.start = 1; a.abort = 1; #1;
      if (a.init !== 1'b0) begin
         $display("FAIL abort_idle_start: init=%b want 0", a.init);
         n_bad++;
      end
      n_cmp++;
      tick; a.start = 0; a.abort = 0;
      if (a.busy !== 1'b0) begin
         $display("FAIL abort_idle_busy: busy=%b want 0", a.busy);
         n_bad++;
      end
      n_cmp++;
      a.start = 1; #1; tick; a.start = 0;
      a.block_valid = 1; a.block_last = 1; a.abort = 1; #1;
      if (a.load !== 1'b0) begin
         $display("FAIL abort_load: load=%b want 0", a.load);
         n_bad++;
      end
      n_cmp++;
      tick; clear_in();
      if (a.busy !== 1'b0 || a.block_cnt !== 8'd0 || a.enable !== 1'b0) begin
         $display("FAIL abort_wait: busy=%b cnt=%0d en=%b want 0 0 0",
                  a.busy, a.block_cnt, a.enable);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_rounds80;
      int n_en = 0;
      int n_rl = 0;
      int rl_round = -1;
      b.start = 1; #1; tick; b.start = 0;
      b.block_valid = 1; b.block_last = 1; #1; tick; b.block_valid = 0; b.block_last = 0;
      for (int k = 0; k < 200 && !b.update; k++) begin
         if (b.enable) n_en++;
         if (b.round_last) begin
            n_rl++;
            rl_round = int'(b.round);
         end
         tick;
      end
      if (n_en !== 80 || n_rl !== 1 || rl_round !== 79 || b.update !== 1'b1) begin
         $display("FAIL r80_rounds: en=%0d rl=%0d at=%0d upd=%b want 80 1 79 1",
                  n_en, n_rl, rl_round, b.update);
         n_bad++;
      end
      n_cmp++;
      tick;
      if (b.digest_valid !== 1'b1) begin
         $display("FAIL r80_dv: got %b want 1", b.digest_valid);
         n_bad++;
      end
      n_cmp++;
      b.digest_ready = 1; #1; tick; b.digest_ready = 0;
   endtask

   task automatic test_saturate;
      b.start = 1; #1; tick; b.start = 0;
      for (int i = 0; i < 5; i++) begin
         b.block_valid = 1; b.block_last = (i == 4); #1;
         if (b.load !== 1'b1) begin
            $display("FAIL sat_load: blk=%0d got %b want 1", i, b.load);
            n_bad++;
         end
         n_cmp++;
         tick; b.block_valid = 0; b.block_last = 0;
         if (b.block_cnt !== 2'((i < 3) ? i + 1 : 3)) begin
            $display("FAIL sat_cnt: blk=%0d got %0d want %0d", i, b.block_cnt, (i < 3) ? i + 1 : 3);
            n_bad++;
         end
         n_cmp++;
         repeat (81) tick;
      end
      if (b.digest_valid !== 1'b1 || b.block_cnt !== 2'd3) begin
         $display("FAIL sat_done: dv=%b cnt=%0d want 1 3", b.digest_valid, b.block_cnt);
         n_bad++;
      end
      n_cmp++;
      b.digest_ready = 1; #1; tick; b.digest_ready = 0;
   endtask

   task automatic test_reset_mid;
      a.start = 1; #1; tick; a.start = 0;
      a.block_valid = 1; a.block_last = 0; #1; tick; a.block_valid = 0;
      repeat (10) tick;
      #2 rst_n = 0;
      #1;
      if ({a.init, a.load, a.enable, a.round_last, a.update, a.digest_valid, a.busy,
           a.block_ready} !== 8'h00 || a.round !== 6'd0 || a.block_cnt !== 8'd0) begin
         $display("FAIL rst_mid: outs=%b round=%0d cnt=%0d want 00000000 0 0",
                  {a.init, a.load, a.enable, a.round_last, a.update, a.digest_valid, a.busy,
                   a.block_ready}, a.round, a.block_cnt);
         n_bad++;
      end
      n_cmp++;
      @(negedge clk) rst_n = 1;
      tick;
      drive_single_a();
      if (a.digest_valid !== 1'b1 || a.block_cnt !== 8'd1) begin
         $display("FAIL rst_recover: dv=%b cnt=%0d want 1 1", a.digest_valid, a.block_cnt);
         n_bad++;
      end
      n_cmp++;
      a.digest_ready = 1; #1; tick; a.digest_ready = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_three_blocks();
      test_backpressure();
      test_abort();
      test_rounds80();
      test_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "timeout");
   end

endmodule
